imem_server: RTL and testbench
==============================

# imem_server

Instruction-memory responder for the fetch path: accepts fetch requests from the IFU over a valid/ready channel, reads a byte-masked, preloadable 64-bit-wide instruction store, and returns the selected 32-bit instruction through a 2-entry response FIFO. It is the memory-side end of the instruction-fetch interface and replaces the DPI-C pmem read with synthesizable storage. The preload port is the writer end used by the bench/loader before and during execution.

## Interface
- CPU_WIDTH, 64, address and storage word width
- DEPTH_LOG2, 12, log2 of number of 64-bit words (4096 words = 32 KiB)
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  fetch request valid
- o_req_ready  out  1  request can be accepted this cycle
- i_req_addr  in  CPU_WIDTH  fetch byte address (pc)
- o_rsp_valid  out  1  response at FIFO head valid
- i_rsp_ready  in  1  consumer takes head this cycle
- o_rsp_ins  out  32  instruction at FIFO head
- o_rsp_err  out  1  head response is an access fault
- i_wr_en  in  1  preload write strobe
- i_wr_addr  in  CPU_WIDTH  preload byte address (bits [2:0] ignored)
- i_wr_data  in  CPU_WIDTH  preload data
- i_wr_mask  in  8  per-byte write enable, bit k -> data[8k+7:8k]

## Operation
- Accept = i_req_valid && o_req_ready; pop = o_rsp_valid && i_rsp_ready.
- o_req_ready = FIFO count < 2; no combinational path from i_rsp_ready or i_req_valid.
- Offset = i_req_addr - BASE_ADDR; in range iff offset < 2^(DEPTH_LOG2+3). Index = offset[DEPTH_LOG2+2:3].
- In range: ins = offset[2] ? word[63:32] : word[31:0], err = 0. Out of range: ins = 32'h0, err = 1, no array access.
- On accept, {ins, err} written into FIFO tail at that edge.
- FIFO: 2 entries, head/tail pointers wrap 1->0, 2-bit count. Push and pop same cycle: count unchanged, order preserved. Pop with push into empty impossible (valid low).
- Write port: on i_wr_en, bytes with mask set updated at index derived as above; out-of-range write silently dropped. Independent of request channel.
- Same-cycle write and accept to same word: response carries pre-write data (read-before-write).
- Storage is not reset; contents survive i_rst.

## Timing
- Reset (i_rst high at edge): count=0, pointers=0; following cycle o_rsp_valid=0, o_rsp_ins=0, o_rsp_err=0, o_req_ready=1. o_req_ready=1 also holds during reset cycles; requests accepted in a cycle with i_rst high are discarded.
- Latency: accept in cycle N -> o_rsp_valid=1 with data in cycle N+1.
- Throughput: 1 request/cycle sustained when i_rsp_ready held high.
- Backpressure: FIFO full (count=2) -> o_req_ready=0 next cycle until a pop; pop in cycle M -> o_req_ready=1 in M+1.
- o_rsp_ins/o_rsp_err stable while o_rsp_valid=1 and not popped; when empty, outputs hold 0.
- Reset mid-stream: all queued responses dropped, no response emitted for them.

## Configuration
- IMEM_MISALIGN_CHK_EN defined: request with i_req_addr[1:0] != 0 returns err=1, ins=32'h0, regardless of range. Undefined: addr[1:0] ignored, word half chosen by offset[2] only.

## Test plan
- Preload index 0 with 64'h0000_0013_0010_0093 (mask 8'hFF); request 0x8000_0000 then 0x8000_0004, rsp ready high -> ins 32'h0010_0093 cycle N+1, 32'h0000_0013 cycle N+2, err 0.
- Hold i_rsp_ready=0, issue 3 back-to-back requests -> first two accepted, o_req_ready=0 on third; release ready -> third accepted cycle after first pop, order intact.
- Request 0x7FFF_FFFC and 0x8000_8000 (DEPTH_LOG2=12) -> err=1, ins=0 both; write to 0x8000_8000 leaves array unchanged.
- Same-cycle write 64'hFFFF_FFFF_FFFF_FFFF mask 8'h0F to index 1 and request 0x8000_0008 -> old word returned; next request same address returns 32'hFFFF_FFFF.
- Fill FIFO, assert i_rst one cycle -> o_rsp_valid=0, o_req_ready=1 next cycle; preloaded data still readable.
- With IMEM_MISALIGN_CHK_EN: request 0x8000_0002 -> err=1, ins=0; without: returns low half of index 0.

Source files
------------

// File: rtl/imem_server.sv
// imem_server: instruction-memory responder for the fetch path.
// Fetch requests arrive on a valid/ready channel, read a byte-maskable,
// preloadable 64-bit instruction store and return the selected 32-bit
// instruction through a 2-entry response FIFO.
// Optional feature macro: IMEM_MISALIGN_CHK_EN (fault non-word-aligned fetches).
module imem_server #(
   parameter int unsigned       CPU_WIDTH  = 64,
   parameter int unsigned       DEPTH_LOG2 = 12,
   parameter logic [63:0]       BASE_ADDR  = 64'h0000_0000_8000_0000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic [CPU_WIDTH-1:0] i_req_addr,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [31:0]          o_rsp_ins,
   output logic                 o_rsp_err,
   input  logic                 i_wr_en,
   input  logic [CPU_WIDTH-1:0] i_wr_addr,
   input  logic [CPU_WIDTH-1:0] i_wr_data,
   input  logic [7:0]           i_wr_mask
);

   localparam int unsigned           DEPTH     = 1 << DEPTH_LOG2;
   localparam int unsigned           SPAN_LOG2 = DEPTH_LOG2 + 3;
   localparam logic [CPU_WIDTH-1:0]  BASE      = CPU_WIDTH'(BASE_ADDR);

   // instruction store (not reset, survives i_rst)
   logic [63:0] mem [0:DEPTH-1];

   // response FIFO
   logic [31:0] fifo_ins [0:1];
   logic        fifo_err [0:1];
   logic        head;
   logic        tail;
   logic [1:0]  count;

   // request decode
   logic [CPU_WIDTH-1:0]  rd_off;
   logic                  rd_in_range;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [63:0]           rd_word;
   logic [31:0]           rd_ins;
   logic                  rd_err;

   // write decode
   logic [CPU_WIDTH-1:0]  wr_off;
   logic                  wr_in_range;
   logic [DEPTH_LOG2-1:0] wr_idx;

   logic accept;
   logic pop;
   logic push;
   logic unused_bits;

   assign rd_off      = i_req_addr - BASE;
   assign rd_in_range = (rd_off[CPU_WIDTH-1:SPAN_LOG2] == '0);
   assign rd_idx      = rd_off[SPAN_LOG2-1:3];

   assign wr_off      = i_wr_addr - BASE;
   assign wr_in_range = (wr_off[CPU_WIDTH-1:SPAN_LOG2] == '0);
   assign wr_idx      = wr_off[SPAN_LOG2-1:3];

   assign unused_bits = ^{rd_off[1:0], wr_off[2:0]};

   assign o_req_ready = ~count[1] | i_rst;
   assign o_rsp_valid = (count != 2'd0);
   assign accept      = i_req_valid & o_req_ready;
   assign pop         = o_rsp_valid & i_rsp_ready;
   assign push        = accept & ~i_rst;

   // select the addressed instruction half, or a fault for an out-of-range/misaligned fetch
   always_comb begin
      rd_word = '0;
      rd_ins  = '0;
      rd_err  = 1'b1;
      if (rd_in_range) begin
         rd_word = mem[rd_idx];
         rd_ins  = rd_off[2] ? rd_word[63:32] : rd_word[31:0];
         rd_err  = 1'b0;
      end
`ifdef IMEM_MISALIGN_CHK_EN
      if (i_req_addr[1:0] != 2'b00) begin
         rd_ins = '0;
         rd_err = 1'b1;
      end
`else
`endif
   end

   // byte-masked preload writes; out-of-range writes are dropped
   always_ff @(posedge i_clk) begin
      if (i_wr_en && wr_in_range) begin
         for (int unsigned k = 0; k < 8; k++) begin
            if (i_wr_mask[k]) mem[wr_idx][8*k +: 8] <= i_wr_data[8*k +: 8];
         end
      end
   end

   // FIFO payload storage; written at the tail on every accepted request
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_ins[tail] <= rd_ins;
         fifo_err[tail] <= rd_err;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // head presentation; zeros while the FIFO is empty
   always_comb begin
      o_rsp_ins = '0;
      o_rsp_err = 1'b0;
      if (o_rsp_valid) begin
         o_rsp_ins = fifo_ins[head];
         o_rsp_err = fifo_err[head];
      end
   end

endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: directed self-checking bench for imem_server.
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_imem_server;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_ins;
   logic        rsp_err;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [63:0] wr_data;
   logic [7:0]  wr_mask;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   imem_server #(
      .CPU_WIDTH  (64),
      .DEPTH_LOG2 (12),
      .BASE_ADDR  (64'h0000_0000_8000_0000)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_addr  (req_addr),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_ins   (rsp_ins),
      .o_rsp_err   (rsp_err),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_wr_mask   (wr_mask)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [31:0] ins, input logic err);
      check({tag, ".valid"}, 64'(rsp_valid), 64'(v));
      check({tag, ".ins"},   64'(rsp_ins),   64'(ins));
      check({tag, ".err"},   64'(rsp_err),   64'(err));
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
      step(); step();
      rst = 1'b0;
      check_rsp("reset", 1'b0, 32'h0, 1'b0);
      check("reset.ready", 64'(req_ready), 64'd1);

      // preload index 0 and index 1
      wr_en = 1'b1; wr_addr = 64'h8000_0000; wr_data = 64'h0000_0013_0010_0093; wr_mask = 8'hFF;
      step();
      wr_addr = 64'h8000_0008; wr_data = 64'h1122_3344_5566_7788;
      step();
      wr_en = 1'b0;

      // basic fetch, one per cycle
      rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h8000_0000;
      step();
      check_rsp("fetch0", 1'b1, 32'h0010_0093, 1'b0);
      req_addr = 64'h8000_0004;
      step();
      check_rsp("fetch1", 1'b1, 32'h0000_0013, 1'b0);
      req_valid = 1'b0;
      step();
      check_rsp("drained", 1'b0, 32'h0, 1'b0);

      // backpressure
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h8000_0000;
      step();
      check("bp.ready1", 64'(req_ready), 64'd1);
      req_addr = 64'h8000_0004;
      step();
      check("bp.full_ready", 64'(req_ready), 64'd0);
      check_rsp("bp.head", 1'b1, 32'h0010_0093, 1'b0);
      req_addr = 64'h8000_0008;
      step();
      check("bp.still_full", 64'(req_ready), 64'd0);
      check_rsp("bp.head_hold", 1'b1, 32'h0010_0093, 1'b0);
      rsp_ready = 1'b1;
      step();
      check("bp.ready_after_pop", 64'(req_ready), 64'd1);
      check_rsp("bp.second", 1'b1, 32'h0000_0013, 1'b0);
      step();
      check_rsp("bp.third", 1'b1, 32'h5566_7788, 1'b0);
      req_valid = 1'b0;
      step();
      check_rsp("bp.empty", 1'b0, 32'h0, 1'b0);

      // out-of-range fetches and a dropped write
      req_valid = 1'b1; req_addr = 64'h7FFF_FFFC;
      step();
      check_rsp("oor.low", 1'b1, 32'h0, 1'b1);
      req_addr = 64'h8000_8000;
      step();
      check_rsp("oor.high", 1'b1, 32'h0, 1'b1);
      req_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 64'h8000_8000; wr_data = 64'hAAAA_AAAA_AAAA_AAAA; wr_mask = 8'hFF;
      step();
      wr_en = 1'b0; req_valid = 1'b1; req_addr = 64'h8000_0000;
      step();
      check_rsp("oor.nowrite", 1'b1, 32'h0010_0093, 1'b0);

      // same-cycle write and fetch of the same word
      wr_en = 1'b1; wr_addr = 64'h8000_0008; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_mask = 8'h0F;
      req_addr = 64'h8000_0008;
      step();
      check_rsp("rbw.old", 1'b1, 32'h5566_7788, 1'b0);
      wr_en = 1'b0;
      step();
      check_rsp("rbw.new", 1'b1, 32'hFFFF_FFFF, 1'b0);
      req_addr = 64'h8000_000C;
      step();
      check_rsp("rbw.high_kept", 1'b1, 32'h1122_3344, 1'b0);
      req_valid = 1'b0;
      step();

      // reset with a full FIFO
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h8000_0000;
      step(); step();
      check("rst.full", 64'(req_ready), 64'd0);
      rst = 1'b1;
      #1;
      check("rst.ready_during", 64'(req_ready), 64'd1);
      step();
      rst = 1'b0; req_valid = 1'b0;
      check_rsp("rst.after", 1'b0, 32'h0, 1'b0);
      check("rst.ready_after", 64'(req_ready), 64'd1);
      rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h8000_0004;
      step();
      check_rsp("rst.mem_kept", 1'b1, 32'h0000_0013, 1'b0);

      // misaligned fetch
      req_addr = 64'h8000_0002;
      step();
`ifdef IMEM_MISALIGN_CHK_EN
      check_rsp("misalign", 1'b1, 32'h0, 1'b1);
`else
      check_rsp("misalign", 1'b1, 32'h0010_0093, 1'b0);
`endif
      req_valid = 1'b0;
      step();
      check_rsp("final.empty", 1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
